// File: rtl/tt_bytepack.sv
// Packs qualified debiased random bits MSB-first into bytes, buffers them in a small FIFO,
// and runs a repetition-count health test that flushes and locks the output when it trips.
module tt_bytepack #(
  parameter int unsigned RCT_LIMIT  = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          bit_in,
  input  logic                          bit_en,
  input  logic                          clr,
  output logic [7:0]                    byte_out,
  output logic                          byte_valid,
  input  logic                          byte_ready,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          overflow,
  output logic                          health_fail
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned LvlW = PtrW + 1;

  typedef enum logic {StFill, StFail} state_e;

  state_e           state_q, state_d;
  logic [6:0]       shift_q, shift_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       rct_q, rct_d;
  logic             prev_q, prev_d;
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0]  level_q, level_d;
  logic             ovf_q, ovf_d;
  logic             fail_q, fail_d;

  logic [7:0]       mem [FIFO_DEPTH];

  logic             accept;
  logic             pop;
  logic             push;
  logic             full;
  logic             wr_en;
  logic             trip;
  logic [7:0]       rct_inc;
  logic [7:0]       new_byte;

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    rct_d     = rct_q;
    prev_d    = prev_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    ovf_d     = ovf_q;
    fail_d    = fail_q;
    wr_en     = 1'b0;

    new_byte = {shift_q, bit_in};
    full     = (level_q == LvlW'(FIFO_DEPTH));
    accept   = (state_q == StFill) && bit_en;
    pop      = (state_q == StFill) && (level_q != '0) && byte_ready;

    // rct_q == 0 marks "no previous bit" after reset or clear
    if ((rct_q != 8'd0) && (bit_in == prev_q)) begin
      rct_inc = (rct_q >= 8'(RCT_LIMIT)) ? rct_q : rct_q + 8'd1;
    end else begin
      rct_inc = 8'd1;
    end
    trip = accept && (rct_inc == 8'(RCT_LIMIT));
    push = accept && !trip && (bit_cnt_q == 3'd7);

    if (clr) begin
      state_d   = StFill;
      shift_d   = '0;
      bit_cnt_d = '0;
      rct_d     = '0;
      prev_d    = 1'b0;
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      level_d   = '0;
      ovf_d     = 1'b0;
      fail_d    = 1'b0;
    end else if (trip) begin
      // The byte this bit would have completed is discarded along with the FIFO.
      state_d   = StFail;
      fail_d    = 1'b1;
      shift_d   = '0;
      bit_cnt_d = '0;
      rct_d     = rct_inc;
      prev_d    = bit_in;
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      level_d   = '0;
    end else begin
      if (accept) begin
        shift_d   = new_byte[6:0];
        bit_cnt_d = bit_cnt_q + 3'd1;
        rct_d     = rct_inc;
        prev_d    = bit_in;
      end

      wr_en = push && (!full || pop);
      if (push && full && !pop) begin
        ovf_d = 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      if (wr_en) begin
        wr_ptr_d = wr_ptr_q + PtrW'(1);
      end

      unique case ({wr_en, pop})
        2'b10:   level_d = level_q + LvlW'(1);
        2'b01:   level_d = level_q - LvlW'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StFill;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      rct_q     <= '0;
      prev_q    <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      ovf_q     <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      rct_q     <= rct_d;
      prev_q    <= prev_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      ovf_q     <= ovf_d;
      fail_q    <= fail_d;
    end
  end

  // Storage is not reset; byte_out is masked to zero whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_q] <= new_byte;
    end
  end

  assign byte_valid  = (state_q == StFill) && (level_q != '0);
  assign byte_out    = byte_valid ? mem[rd_ptr_q] : 8'h00;
  assign level       = level_q;
  assign overflow    = ovf_q;
  assign health_fail = fail_q;

endmodule
